// File: rtl/path_delay_meas_ctrl.sv
// path_delay_meas_ctrl: measures a chained path's delay by toggling its input and counting cycles until the synchronized output follows.
// Ports:
//   clk, rst      single rising-edge clock, asynchronous active-high reset
//   start         one-cycle measurement request, honoured only while idle
//   pathResult    asynchronous delay-chain output, synchronized internally
//   pathInput     flop-driven launch level into the chain
//   busy          high while a measurement is running
//   done          one-cycle pulse when a measurement ends
//   timeout       sticky error flag, cleared by the next accepted start
//   result        accumulated cycle count over all repetitions
module path_delay_meas_ctrl #(
  parameter int CNT_W       = 16,
  parameter int REPS_LOG2   = 3,
  parameter int TIMEOUT_CYC = 4095,
  parameter int SETTLE_CYC  = 8,
  parameter bit INVERT      = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pathResult,
  output logic                       pathInput,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [CNT_W+REPS_LOG2-1:0] result
);
  localparam int ACC_W = CNT_W + REPS_LOG2;
  localparam int TMAX = TIMEOUT_CYC > SETTLE_CYC ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [REPS_LOG2:0] NREPS = (REPS_LOG2+1)'(2 ** REPS_LOG2);
  typedef enum logic [2:0] {IDLE, PRECHECK, LAUNCH, WAIT, SETTLE, FINISH} stateT;
  stateT state;
  logic syncQ1, syncQ2;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [REPS_LOG2:0] reps;
  logic [TW-1:0] tmr;
  logic settled;
  assign settled = syncQ2 == (pathInput ^ INVERT);
  // tmr bounds PRECHECK, WAIT and SETTLE; cnt is the saturating per-repetition count,
  // so a narrow CNT_W never stops the timeout from firing.
  // done is checked in IDLE so a start cannot be accepted during the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      syncQ1    <= 1'b0;
      syncQ2    <= 1'b0;
      pathInput <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      acc       <= '0;
      reps      <= '0;
      tmr       <= '0;
    end else begin
      syncQ1 <= pathResult;
      syncQ2 <= syncQ1;
      done   <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          acc     <= '0;
          reps    <= '0;
          tmr     <= '0;
          timeout <= 1'b0;
          busy    <= 1'b1;
          state   <= PRECHECK;
        end
        PRECHECK: if (settled) state <= LAUNCH;
          else if (tmr == TW'(TIMEOUT_CYC - 1)) begin
            timeout <= 1'b1;
            state   <= FINISH;
          end else tmr <= tmr + TW'(1);
        LAUNCH: begin
          pathInput <= ~pathInput;
          cnt       <= '0;
          tmr       <= '0;
          state     <= WAIT;
        end
        WAIT: if (settled) begin
            acc   <= acc + ACC_W'(cnt);
            reps  <= reps + (REPS_LOG2+1)'(1);
            tmr   <= '0;
            state <= SETTLE;
          end else if (tmr == TW'(TIMEOUT_CYC)) begin
            timeout <= 1'b1;
            state   <= FINISH;
          end else begin
            tmr <= tmr + TW'(1);
            cnt <= &cnt ? cnt : cnt + CNT_W'(1);
          end
        SETTLE: if (tmr == TW'(SETTLE_CYC - 1)) state <= reps == NREPS ? FINISH : LAUNCH;
          else tmr <= tmr + TW'(1);
        FINISH: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_path_delay_meas_ctrl.sv
// tb_path_delay_meas_ctrl: directed scoreboard bench driving two configurations against loopback, delay, stuck and inverting path models.
module tb_path_delay_meas_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] start = '0;
  logic [1:0] pathResult, pathInput, busy, done, timeout;
  logic [9:0] res0;
  logic [6:0] res1;
  logic [63:0] hist0, hist1;
  int mode0 = 0, mode1 = 3, dly0 = 1, dly1 = 1;
  int nAsserts = 0, nFail = 0;
  typedef struct {int res; logic to; logic pi;} expT;
  expT sb[$];

  path_delay_meas_ctrl #(.CNT_W(8), .REPS_LOG2(2), .TIMEOUT_CYC(15), .SETTLE_CYC(3), .INVERT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .pathResult(pathResult[0]), .pathInput(pathInput[0]),
    .busy(busy[0]), .done(done[0]), .timeout(timeout[0]), .result(res0));
  path_delay_meas_ctrl #(.CNT_W(4), .REPS_LOG2(3), .TIMEOUT_CYC(63), .SETTLE_CYC(1), .INVERT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .pathResult(pathResult[1]), .pathInput(pathInput[1]),
    .busy(busy[1]), .done(done[1]), .timeout(timeout[1]), .result(res1));

  // modes: 0 loopback, 1 delay line, 2 stuck at 0, 3 inverting loopback, 4 inverting delay line
  function automatic logic pathModel(int m, int d, logic pi, logic [63:0] h);
    return m == 0 ? pi : m == 1 ? h[d-1] : m == 2 ? 1'b0 : m == 3 ? ~pi : ~h[d-1];
  endfunction

  always_ff @(posedge clk)
    if (rst) begin
      hist0 <= '0;
      hist1 <= '0;
    end else begin
      hist0 <= {hist0[62:0], pathInput[0]};
      hist1 <= {hist1[62:0], pathInput[1]};
    end

  always_comb begin
    pathResult[0] = pathModel(mode0, dly0, pathInput[0], hist0);
    pathResult[1] = pathModel(mode1, dly1, pathInput[1], hist1);
  end

  function automatic int expRes(int lat, int nReps, int cntW);
    int sat = (1 << cntW) - 1;
    return nReps * (lat < sat ? lat : sat);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic meas(input int u, input int eRes, input logic eTo, input logic ePi, input bit spam, input string tag);
    bit got = 0, busyOk = 1;
    int extra = 0;
    expT e;
    sb.push_back('{eRes, eTo, ePi});
    @(negedge clk) start[u] = 1'b1;
    @(negedge clk) start[u] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done[u]) begin
        got = 1;
        break;
      end
      if (!busy[u]) busyOk = 0;
      start[u] = spam;
    end
    start[u] = 1'b0;
    chk({tag, " done seen"}, int'(got), 1);
    e = sb.pop_front();
    if (got) begin
      chk({tag, " result"}, int'(u == 1 ? 10'(res1) : res0), e.res);
      chk({tag, " timeout"}, int'(timeout[u]), int'(e.to));
      chk({tag, " pathInput"}, int'(pathInput[u]), int'(e.pi));
      chk({tag, " busy held"}, int'(busyOk), 1);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done[u]) extra++;
    end
    chk({tag, " single done"}, extra, 0);
  endtask

  initial begin
    int extra;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset timeout", int'(timeout), 0);
    chk("reset pathInput", int'(pathInput), 0);
    chk("reset res0", int'(res0), 0);
    chk("reset res1", int'(res1), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mode0 = 0;
    meas(0, expRes(2, 4, 8), 1'b0, 1'b0, 0, "loopback");
    mode0 = 1; dly0 = 10;
    meas(0, expRes(12, 4, 8), 1'b0, 1'b0, 0, "delay10");
    dly0 = 13;
    meas(0, expRes(15, 4, 8), 1'b0, 1'b0, 0, "delay13 edge");
    mode0 = 0;
    meas(0, expRes(2, 4, 8), 1'b0, 1'b0, 1, "start spam");
    mode0 = 3;
    meas(0, 0, 1'b1, 1'b0, 0, "inv no-invert precheck");
    mode0 = 0;
    meas(0, expRes(2, 4, 8), 1'b0, 1'b0, 0, "timeout cleared");
    mode0 = 2;
    meas(0, 0, 1'b1, 1'b1, 0, "stuck0");
    mode0 = 1; dly0 = 14;
    meas(0, 0, 1'b1, 1'b0, 0, "delay14 over");
    mode1 = 3;
    meas(1, expRes(2, 8, 4), 1'b0, 1'b0, 0, "invert loopback");
    mode1 = 4; dly1 = 20;
    meas(1, expRes(22, 8, 4), 1'b0, 1'b0, 0, "saturate");
    mode0 = 1; dly0 = 10;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre-abort busy", int'(busy[0]), 1);
    rst = 1'b1;
    #1;
    chk("abort busy", int'(busy[0]), 0);
    chk("abort pathInput", int'(pathInput[0]), 0);
    chk("abort done", int'(done[0]), 0);
    chk("abort timeout", int'(timeout[0]), 0);
    chk("abort result", int'(res0), 0);
    @(negedge clk) rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[0]) extra++;
    end
    chk("abort no done", extra, 0);
    mode0 = 0;
    meas(0, expRes(2, 4, 8), 1'b0, 1'b0, 0, "rerun");
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end
endmodule
